switch_event_arbiter: RTL
=========================

# switch_event_arbiter

Collects release events (falling edges) from several debounced switch lines and shares one LED-toggle / event-output path among them. Edges are queued per channel and granted round-robin. Each grant is offered downstream with a valid/ready handshake, then followed by a programmable hold-off. Sits between the per-switch debounce stage and the LED/consumer logic, and replaces ad-hoc per-switch toggle flops.

## Interface
- NUM_CH, 4: number of switch channels (2..8).
- CH_W, 2: width of channel index, equal to clog2(NUM_CH).
- HOLDOFF_CYCLES, 250000: idle cycles after each accepted event (10 ms at 25 MHz); 0 means no hold-off.
- CNT_W, 18: hold-off counter width; must hold HOLDOFF_CYCLES.

- i_Clk  in  1  25 MHz system clock, all logic on posedge.
- i_Rst  in  1  asynchronous, active-high reset.
- i_Switch  in  NUM_CH  debounced switch levels, synchronous to i_Clk.
- i_Ready  in  1  downstream accepts the offered event.
- o_Valid  out  1  event offered; reset 0.
- o_Chan  out  CH_W  channel of the offered event; reset 0.
- o_LED  out  NUM_CH  per-channel toggle state; reset all 0.
- o_Pending  out  NUM_CH  queued, not-yet-granted events; reset all 0.
- o_Drop  out  1  one-cycle pulse when an edge is lost; reset 0.
- o_Busy  out  1  high whenever FSM is not IDLE; reset 0.

## Operation
- Per channel: history register r_Hist (reset 0). Edge condition: r_Hist=1 and i_Switch=0. r_Hist takes i_Switch every cycle.
- Edge on a non-pending channel sets its o_Pending bit.
- Edge on an already-pending channel, or on the channel currently offered: pending is unchanged, o_Drop pulses. At most one drop pulse per cycle (OR across channels).
- Edge arriving in the same cycle its pending bit is cleared by a grant: set wins, so the bit stays 1.
- FSM states: IDLE, OFFER, HOLDOFF.
  - IDLE: if any o_Pending bit is set, pick the first set bit searching upward from r_Last+1, wrapping modulo NUM_CH. Then: load o_Chan, clear that pending bit, set o_Valid=1, set r_Last=chan, go to OFFER.
  - OFFER: o_Valid and o_Chan stay stable until i_Ready=1. On acceptance: o_Valid=0, o_LED[o_Chan] inverts, and the counter loads HOLDOFF_CYCLES-1.
    - HOLDOFF_CYCLES>0: go to HOLDOFF.
    - HOLDOFF_CYCLES=0: go to IDLE.
  - HOLDOFF: counter decrements each cycle; go to IDLE when it reads 0. Edges continue to queue; no grants are made.
- r_Last resets to NUM_CH-1, so channel 0 has first priority after reset.
- Reset asserted mid-operation clears all state asynchronously: o_Valid drops immediately, and queued events are discarded.
- Switch edges are always captured regardless of FSM state.

## Timing
- Switch low sampled at edge k (with r_Hist=1): o_Pending bit high after edge k.
- Grant at edge k+1 if FSM is IDLE: o_Valid high and pending bit low after k+1.
- With i_Ready held high, acceptance is at edge k+2. o_LED toggles after k+2, and o_Valid is low after k+2.
- Minimum spacing between accepted events is HOLDOFF_CYCLES+2 cycles (acceptance, HOLDOFF_CYCLES counter cycles, IDLE grant).
- o_Busy is registered alongside the state: high from the grant edge through the last HOLDOFF cycle.
- o_Drop is high for the single cycle following the offending edge sample.

## Structure
- Shared package/include holds:
  - FSM state encoding (IDLE=0, OFFER=1, HOLDOFF=2);
  - default NUM_CH;
  - HOLDOFF_CYCLES default, derived from the 25 MHz clock constant.
- One sub-module: sw_release_queue, instantiated per channel. It contains r_Hist, edge detect, the pending bit with set-over-clear priority, and the drop flag.
- Round-robin pick and FSM stay in the top level.

## Test plan
- Reset, then one press/release on channel 2 with i_Ready=1: o_Pending=0100 one cycle after the release sample; o_Valid and o_Chan=2 one cycle later; o_LED=0100 one cycle after that; o_Busy low after HOLDOFF_CYCLES further cycles.
- Releases on channels 0, 1, 3 in the same cycle with HOLDOFF_CYCLES=4: grants in order 0, 1, 3. Accepted events are 6 cycles apart (HOLDOFF_CYCLES+2). Final o_LED=1011.
- Hold i_Ready=0 for 10 cycles while offering channel 1: o_Valid and o_Chan stay stable. A second release on channel 1 during the offer gives an o_Drop pulse with o_Pending[1] unchanged. Raising i_Ready gives acceptance in that cycle.
- Release on channel 0 in the exact cycle its pending bit is granted: o_Pending[0] stays 1 and channel 0 is re-offered after the hold-off.
- Assert i_Rst asynchronously during OFFER and again during HOLDOFF: all outputs return to 0 without waiting for a clock edge. After release, the first grant goes to channel 0 when channels 0 and 3 are both pending.
- HOLDOFF_CYCLES=0, back-to-back releases on channels 2 and 3: events accepted 2 cycles apart; HOLDOFF state never entered.

Source files
------------

// File: rtl/switch_event_arbiter_pkg.sv
// Shared types and defaults for the switch release-event arbiter.
package switch_event_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    localparam int DEF_NUM_CH         = 4;
    localparam int CLK_HZ             = 25_000_000;
    localparam int HOLDOFF_MS         = 10;
    localparam int DEF_HOLDOFF_CYCLES = CLK_HZ / 1000 * HOLDOFF_MS;

endpackage

// File: rtl/switch_event_arbiter_if.sv
// Valid/ready event channel from the arbiter to the LED/consumer logic.
interface switch_event_arbiter_if #(
    parameter int CH_W = 2
);
    logic            o_Valid;
    logic [CH_W-1:0] o_Chan;
    logic            i_Ready;

    modport master (output o_Valid, output o_Chan, input i_Ready);
    modport slave  (input o_Valid, input o_Chan, output i_Ready);
endinterface

// File: rtl/switch_event_arbiter_queue.sv
// Per-channel release detector with a one-deep pending flag and loss flag.
module sw_release_queue
    import switch_event_arbiter_pkg::*;
(
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    input  logic i_Clear,
    input  logic i_Offered,
    output logic o_Pending,
    output logic o_Drop
);

    logic r_Hist;
    logic w_Edge;
    logic w_Lost;

    // A release that cannot be queued is lost; a grant clearing the flag frees the slot.
    always_comb begin
        w_Edge = r_Hist & ~i_Switch;
        w_Lost = w_Edge & ((o_Pending & ~i_Clear) | i_Offered);
    end

    // History, pending flag (set beats clear) and one-cycle loss flag.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Hist    <= 1'b0;
            o_Pending <= 1'b0;
            o_Drop    <= 1'b0;
        end else begin
            r_Hist <= i_Switch;
            o_Drop <= w_Lost;
            if (w_Edge && !w_Lost) begin
                o_Pending <= 1'b1;
            end else if (i_Clear) begin
                o_Pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/switch_event_arbiter.sv
// Round-robin arbiter sharing one event/LED-toggle path among switch releases.
module switch_event_arbiter
    import switch_event_arbiter_pkg::*;
#(
    parameter int NUM_CH         = DEF_NUM_CH,
    parameter int CH_W           = 2,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int CNT_W          = 18
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [NUM_CH-1:0]     i_Switch,
    switch_event_arbiter_if.master evt,
    output logic [NUM_CH-1:0]     o_LED,
    output logic [NUM_CH-1:0]     o_Pending,
    output logic                  o_Drop,
    output logic                  o_Busy
);

    localparam logic [CNT_W-1:0] HOLD_LOAD =
        (HOLDOFF_CYCLES == 0) ? '0 : CNT_W'(HOLDOFF_CYCLES - 1);

    state_t              r_State;
    state_t              w_Next;
    logic [CH_W-1:0]     r_Last;
    logic [CNT_W-1:0]    r_Cnt;
    logic [CH_W-1:0]     w_Idx;
    logic [CH_W-1:0]     w_Pick;
    logic                w_Found;
    logic                w_Grant;
    logic                w_Accept;
    logic [NUM_CH-1:0]   w_Clear;
    logic [NUM_CH-1:0]   w_Offered;
    logic [NUM_CH-1:0]   w_Drop;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sw_release_queue u_queue (
            .i_Clk     (i_Clk),
            .i_Rst     (i_Rst),
            .i_Switch  (i_Switch[g]),
            .i_Clear   (w_Clear[g]),
            .i_Offered (w_Offered[g]),
            .o_Pending (o_Pending[g]),
            .o_Drop    (w_Drop[g])
        );
    end

    assign o_Drop = |w_Drop;

    // Round-robin search: first pending channel after the last grant, wrapping.
    always_comb begin
        w_Found = 1'b0;
        w_Pick  = '0;
        w_Idx   = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            w_Idx = CH_W'((32'(r_Last) + i) % NUM_CH);
            if (!w_Found && o_Pending[w_Idx]) begin
                w_Found = 1'b1;
                w_Pick  = w_Idx;
            end
        end
    end

    // Next-state decision.
    always_comb begin
        w_Next = r_State;
        case (r_State)
            IDLE:    if (|o_Pending) w_Next = OFFER;
            OFFER:   if (evt.i_Ready) w_Next = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
            HOLDOFF: if (r_Cnt == '0) w_Next = IDLE;
            default: w_Next = IDLE;
        endcase
    end

    // Per-state actions feeding the datapath and the per-channel queues.
    always_comb begin
        w_Grant   = (r_State == IDLE) && w_Found;
        w_Accept  = (r_State == OFFER) && evt.i_Ready;
        w_Clear   = w_Grant ? (NUM_CH'(1) << w_Pick) : '0;
        w_Offered = evt.o_Valid ? (NUM_CH'(1) << evt.o_Chan) : '0;
    end

    // State register with valid/busy registered alongside it.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_State     <= IDLE;
            evt.o_Valid <= 1'b0;
            o_Busy      <= 1'b0;
        end else begin
            r_State     <= w_Next;
            evt.o_Valid <= (w_Next == OFFER);
            o_Busy      <= (w_Next != IDLE);
        end
    end

    // Granted channel, round-robin pointer, LED toggles and hold-off counter.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            evt.o_Chan <= '0;
            r_Last     <= CH_W'(NUM_CH - 1);
            r_Cnt      <= '0;
            o_LED      <= '0;
        end else begin
            if (w_Grant) begin
                evt.o_Chan <= w_Pick;
                r_Last     <= w_Pick;
            end
            if (w_Accept) begin
                o_LED <= o_LED ^ (NUM_CH'(1) << evt.o_Chan);
                r_Cnt <= HOLD_LOAD;
            end else if (r_State == HOLDOFF && r_Cnt != '0) begin
                r_Cnt <= r_Cnt - CNT_W'(1);
            end
        end
    end

endmodule
